// File: rtl/ysyx_22041752_icache_axi_rd_if.sv
// Signal bundle between the icache refill bridge, the cache-side SRAM port and the AXI4 read channels.
// master = the bridge; slave = the cache plus the AXI read slave.
interface ysyx_22041752_icache_axi_rd_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 64
);
  logic               sram_req;
  logic               sram_ready;
  logic [ADDR_WD-1:0] sram_addr;
  logic [DATA_WD-1:0] sram_rdata;
  logic               sram_valid;
  logic               rd_err;

  logic               arvalid;
  logic               arready;
  logic [ADDR_WD-1:0] araddr;
  logic [3:0]         arid;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;

  logic               rvalid;
  logic               rready;
  logic [DATA_WD-1:0] rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic [3:0]         rid;

  modport master (
    input  sram_req, sram_addr,
    output sram_ready, sram_rdata, sram_valid, rd_err,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    output sram_req, sram_addr,
    input  sram_ready, sram_rdata, sram_valid, rd_err,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/ysyx_22041752_icache_axi_rd.sv
// Icache line refill bridge: one AXI4 INCR read burst per miss, beats forwarded to the cache
// one cycle after each R handshake.
//
// state | meaning
// IDLE  | waiting for a miss request; sram_ready high
// AR    | burst address presented, waiting for arready
// R     | collecting BURST_LEN beats, each forwarded as a sram_valid pulse
module ysyx_22041752_icache_axi_rd #(
  parameter int         ADDR_WD   = 32,
  parameter int         DATA_WD   = 64,
  parameter int         BURST_LEN = 4,
  parameter logic [3:0] ID        = 4'd0
) (
  input logic                           clk,
  input logic                           reset,
  ysyx_22041752_icache_axi_rd_if.master bus
);
  localparam int LINE_BYTES = BURST_LEN * DATA_WD / 8;
  localparam int OFF_WD     = $clog2(LINE_BYTES);
  localparam int CNT_WD     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_WD-1:0] LAST_BEAT = CNT_WD'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R
  } state_t;

  state_t            state;
  logic [CNT_WD-1:0] beat_cnt;
  logic              beat;
  logic              final_beat;
  logic              beat_bad;
  logic              unused_rid;

  assign beat       = (state == S_R) & bus.rvalid;
  assign final_beat = (beat_cnt == LAST_BEAT);
  // rlast is only checked, never trusted: the local beat count ends the burst.
  assign beat_bad   = (bus.rresp != 2'b00) | (bus.rlast != final_beat);
  assign unused_rid = ^bus.rid;

  assign bus.sram_ready = (state == S_IDLE);
  assign bus.arid       = ID;
  assign bus.arlen      = 8'(BURST_LEN - 1);
  assign bus.arsize     = 3'($clog2(DATA_WD / 8));
  assign bus.arburst    = 2'b01;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      beat_cnt       <= '0;
      bus.arvalid    <= 1'b0;
      bus.rready     <= 1'b0;
      bus.araddr     <= '0;
      bus.sram_valid <= 1'b0;
      bus.sram_rdata <= '0;
      bus.rd_err     <= 1'b0;
    end else begin
      bus.sram_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.sram_req) begin
            bus.araddr  <= {bus.sram_addr[ADDR_WD-1:OFF_WD], {OFF_WD{1'b0}}};
            bus.arvalid <= 1'b1;
            state       <= S_AR;
          end
        end
        S_AR: begin
          if (bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
            beat_cnt    <= '0;
            state       <= S_R;
          end
        end
        S_R: begin
          if (beat) begin
            bus.sram_rdata <= bus.rdata;
            bus.sram_valid <= 1'b1;
            if (beat_bad) bus.rd_err <= 1'b1;
            if (final_beat) begin
              beat_cnt   <= '0;
              bus.rready <= 1'b0;
              state      <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          bus.arvalid <= 1'b0;
          bus.rready  <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22041752_icache_axi_rd.sv
// Directed bench for the icache refill bridge: drives cache requests and an AXI read slave
// cycle by cycle and compares every output against hand-derived expectations.
module tb_ysyx_22041752_icache_axi_rd;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic err_model;

  ysyx_22041752_icache_axi_rd_if #(.ADDR_WD(32), .DATA_WD(64)) bus ();

  ysyx_22041752_icache_axi_rd #(
    .ADDR_WD  (32),
    .DATA_WD  (64),
    .BURST_LEN(4),
    .ID       (4'd0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 ns");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full refill. pat/plen give the rvalid pattern (LSB first, continuous once exhausted);
  // err_beat gets rresp=SLVERR; rlast_mask marks beats carrying rlast; rst_beat pulses reset.
  task automatic refill(input logic [31:0] addr, input logic [63:0] base, input int stall,
                        input logic [15:0] pat, input int plen, input int err_beat,
                        input logic [3:0] rlast_mask, input logic hold,
                        input logic [31:0] next_addr, input int rst_beat);
    logic [31:0] line;
    logic        v;
    logic        bad;
    logic        exp_sv;
    logic [63:0] exp_sd;
    int          beat;
    int          i;
    int          pulses;
    line = addr & 32'hFFFF_FFE0;
    check_val("idle_ready", bus.sram_ready, 1);
    bus.sram_req  = 1'b1;
    bus.sram_addr = addr;
    tick();
    bus.sram_req  = hold;
    bus.sram_addr = next_addr;
    check_val("ar_valid", bus.arvalid, 1);
    check_val("ar_addr", bus.araddr, line);
    check_val("ar_len", bus.arlen, 3);
    check_val("ar_size", bus.arsize, 3);
    check_val("ar_burst", bus.arburst, 1);
    check_val("ar_id", bus.arid, 0);
    check_val("ar_busy", bus.sram_ready, 0);
    check_val("ar_rready", bus.rready, 0);
    for (int k = 0; k < stall; k++) begin
      // Garbage R traffic while in AR must be ignored (rready is low).
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rdata   = 64'hDEAD_BEEF_DEAD_BEEF;
      bus.rresp   = 2'b10;
      bus.rlast   = 1'b1;
      tick();
      check_val("ar_hold_valid", bus.arvalid, 1);
      check_val("ar_hold_addr", bus.araddr, line);
      check_val("ar_hold_busy", bus.sram_ready, 0);
      check_val("ar_hold_err", bus.rd_err, err_model);
    end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    beat   = 0;
    i      = 0;
    pulses = 0;
    exp_sv = 1'b0;
    exp_sd = '0;
    while (beat < 4) begin
      check_val("r_rready", bus.rready, 1);
      check_val("r_arvalid", bus.arvalid, 0);
      check_val("r_addr", bus.araddr, line);
      check_val("r_busy", bus.sram_ready, 0);
      check_val("r_sram_valid", bus.sram_valid, exp_sv);
      if (exp_sv) check_val("r_sram_rdata", bus.sram_rdata, exp_sd);
      check_val("r_err", bus.rd_err, err_model);
      if (bus.sram_valid) pulses++;
      v = (i < plen) ? pat[i] : 1'b1;
      bus.rvalid = v;
      bus.rdata  = v ? base + 64'(beat) : 64'h0;
      bus.rresp  = (v && beat == err_beat) ? 2'b10 : 2'b00;
      bus.rlast  = v & rlast_mask[beat];
      bad = v && ((beat == err_beat) || (rlast_mask[beat] != (beat == 3)));
      if (beat == rst_beat) begin
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        bus.sram_req = 1'b0;
        err_model  = 1'b0;
        check_val("rst_arvalid", bus.arvalid, 0);
        check_val("rst_rready", bus.rready, 0);
        check_val("rst_sram_valid", bus.sram_valid, 0);
        check_val("rst_ready", bus.sram_ready, 1);
        check_val("rst_err", bus.rd_err, 0);
        return;
      end
      tick();
      if (bad) err_model = 1'b1;
      exp_sv = v;
      if (v) begin
        exp_sd = base + 64'(beat);
        beat++;
      end
      i++;
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
    check_val("end_sram_valid", bus.sram_valid, 1);
    check_val("end_sram_rdata", bus.sram_rdata, base + 64'd3);
    check_val("end_pulse_cnt", 64'(pulses) + 64'(bus.sram_valid), 4);
    check_val("end_ready", bus.sram_ready, 1);
    check_val("end_rready", bus.rready, 0);
    check_val("end_err", bus.rd_err, err_model);
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    err_model     = 1'b0;
    reset         = 1'b1;
    bus.sram_req  = 1'b0;
    bus.sram_addr = '0;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = 2'b00;
    bus.rlast     = 1'b0;
    bus.rid       = 4'd0;
    repeat (2) tick();
    check_val("rst_state_ready", bus.sram_ready, 1);
    check_val("rst_state_arvalid", bus.arvalid, 0);
    check_val("rst_state_rready", bus.rready, 0);
    check_val("rst_state_sv", bus.sram_valid, 0);
    check_val("rst_state_sd", bus.sram_rdata, 0);
    check_val("rst_state_araddr", bus.araddr, 0);
    check_val("rst_state_err", bus.rd_err, 0);
    reset = 1'b0;
    tick();

    // single refill, continuous beats
    refill(32'h8000_0014, 64'hA000_0000_0000_0000, 0, 16'h0, 0, -1, 4'b1000, 1'b0, 32'h0, -1);
    tick();
    // AR backpressure for 3 cycles
    refill(32'h8000_1238, 64'hB000_0000_0000_0010, 3, 16'h0, 0, -1, 4'b1000, 1'b0, 32'h0, -1);
    tick();
    // rvalid pattern 1,0,0,1,1,0,1
    refill(32'h8000_2000, 64'hC000_0000_0000_0020, 0, 16'h0059, 7, -1, 4'b1000, 1'b0, 32'h0, -1);
    tick();
    // back-to-back: next request held through the first refill
    refill(32'h8000_0020, 64'hD000_0000_0000_0030, 1, 16'h0, 0, -1, 4'b1000, 1'b1, 32'h8000_0040, -1);
    refill(32'h8000_0040, 64'hD100_0000_0000_0040, 0, 16'h0, 0, -1, 4'b1000, 1'b0, 32'h0, -1);
    // reset on beat 2, then a clean refill
    refill(32'h8000_3010, 64'hE000_0000_0000_0050, 0, 16'h0, 0, -1, 4'b1000, 1'b0, 32'h0, 2);
    refill(32'h8000_3010, 64'hE100_0000_0000_0060, 0, 16'h0, 0, -1, 4'b1000, 1'b0, 32'h0, -1);
    tick();
    // SLVERR on beat 2, error stays sticky through a clean refill
    refill(32'h8000_4008, 64'hF000_0000_0000_0070, 0, 16'h0, 0, 2, 4'b1000, 1'b0, 32'h0, -1);
    refill(32'h8000_5000, 64'hF100_0000_0000_0080, 0, 16'h0, 0, -1, 4'b1000, 1'b0, 32'h0, -1);
    check_val("err_sticky", bus.rd_err, 1);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    err_model = 1'b0;
    check_val("err_cleared", bus.rd_err, 0);
    tick();
    // early rlast on beat 1: still four beats
    refill(32'h8000_6018, 64'h9000_0000_0000_0090, 0, 16'h0, 0, -1, 4'b0010, 1'b0, 32'h0, -1);
    check_val("rlast_err", bus.rd_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
